// File: rtl/alu_pipe.sv
// Handshaked, width-parametrised ALU with registered result/flags and an
// iterative shift-add multiplier for MUL/MULHU.
module alu_pipe #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_MULHU = 4'd3;
    localparam logic [3:0] OP_SLL   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_ROL   = 4'd6;
    localparam logic [3:0] OP_ROR   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_NOR   = 4'd11;
    localparam logic [3:0] OP_NAND  = 4'd12;
    localparam logic [3:0] OP_XNOR  = 4'd13;
    localparam logic [3:0] OP_SLTU  = 4'd14;
    localparam logic [3:0] OP_EQ    = 4'd15;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        MULT
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mshift;
    logic [WIDTH-1:0]   mb;
    logic               mhigh;
    logic [SHW-1:0]     cnt;

    logic               in_fire;
    logic               is_mul;
    logic [SHW-1:0]     sh;
    logic [SHW:0]       inv_sh;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mul_res;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign is_mul   = (op == OP_MUL) || (op == OP_MULHU);
    assign sh       = b[SHW-1:0];
    // Complementary shift for rotates; a shift of WIDTH yields zero when sh == 0.
    assign inv_sh   = (SHW+1)'(WIDTH) - {1'b0, sh};
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  alu_res = a << sh;
            OP_SRL:  alu_res = a >> sh;
            OP_ROL:  alu_res = (a << sh) | (a >> inv_sh);
            OP_ROR:  alu_res = (a >> sh) | (a << inv_sh);
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_NAND: alu_res = ~(a & b);
            OP_XNOR: alu_res = ~(a ^ b);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
            default: alu_res = '0;
        endcase
    end

    // One partial product per cycle: the multiplicand walks left, the multiplier right.
    assign acc_next = acc + (mb[0] ? mshift : '0);
    assign mul_res  = mhigh ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            acc       <= '0;
            mshift    <= '0;
            mb        <= '0;
            mhigh     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire && is_mul) begin
                        mshift    <= {{WIDTH{1'b0}}, a};
                        mb        <= b;
                        mhigh     <= op[0];
                        acc       <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= MULT;
                    end else if (in_fire) begin
                        result    <= alu_res;
                        carry     <= alu_c;
                        overflow  <= alu_v;
                        zero      <= (alu_res == '0);
                        negative  <= alu_res[WIDTH-1];
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MULT: begin
                    acc    <= acc_next;
                    mshift <= mshift << 1;
                    mb     <= mb >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        result    <= mul_res;
                        carry     <= (acc_next[2*WIDTH-1:WIDTH] != '0);
                        overflow  <= 1'b0;
                        zero      <= (mul_res == '0);
                        negative  <= mul_res[WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every consumed output.
module tb_alu_pipe;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_MULHU = 4'd3;
    localparam logic [3:0] OP_SLL   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_ROL   = 4'd6;
    localparam logic [3:0] OP_ROR   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_NOR   = 4'd11;
    localparam logic [3:0] OP_SLTU  = 4'd14;
    localparam logic [3:0] OP_EQ    = 4'd15;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        negative;

    int   nChecks = 0;
    int   nFails  = 0;
    int   runLen  = 0;
    int   maxRun  = 0;
    exp_t expq[$];
    string nameq[$];

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] r, input logic c, input logic v,
                                input logic z, input logic n);
        exp_t e;
        e.res = r;
        e.c   = c;
        e.v   = v;
        e.z   = z;
        e.n   = n;
        return e;
    endfunction

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Drive one operand set and hold it until the DUT takes it.
    task automatic applyStimulus(input string nm, input logic [3:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input exp_t e, input bit push,
                                 output int waited);
        waited   = 0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                checkOutput({nm, "_accept_timeout"}, 64'(waited), 64'd0);
                break;
            end
        end
        if (push) begin
            expq.push_back(e);
            nameq.push_back(nm);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            runLen = 0;
        end else if (out_valid) begin
            runLen++;
            if (runLen > maxRun) maxRun = runLen;
            if (out_ready) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_result", {32'd0, result}, 64'hDEAD_0000_0000_0000);
                end else begin
                    exp_t e;
                    string nm;
                    e  = expq.pop_front();
                    nm = nameq.pop_front();
                    checkOutput(nm, {28'd0, result, carry, overflow, zero, negative}, {28'd0, e});
                end
            end
        end else begin
            runLen = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int w;
        int n;
        int cnt;
        bit allLow;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {28'd0, out_valid, result, carry, overflow, zero, negative}, 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        applyStimulus("add_basic", OP_ADD, 32'h1A, 32'hB2, mk(32'hCC, 0, 0, 0, 0), 1, w);
        checkOutput("add_latency1", 64'(out_valid), 64'd1);
        applyStimulus("sub_borrow", OP_SUB, 32'h1A, 32'hB2, mk(32'hFFFF_FF68, 1, 0, 0, 1), 1, w);
        applyStimulus("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 0, 1, 0, 1), 1, w);
        applyStimulus("add_carry_zero", OP_ADD, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 1, 0, 1, 0), 1, w);
        applyStimulus("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, mk(32'h7FFF_FFFF, 0, 1, 0, 0), 1, w);
        applyStimulus("ror_1", OP_ROR, 32'h1, 32'h1, mk(32'h8000_0000, 0, 0, 0, 1), 1, w);
        applyStimulus("sll_mod", OP_SLL, 32'h3, 32'h21, mk(32'h6, 0, 0, 0, 0), 1, w);
        applyStimulus("rol_4", OP_ROL, 32'h8000_0001, 32'h4, mk(32'h18, 0, 0, 0, 0), 1, w);
        applyStimulus("rol_0", OP_ROL, 32'hA5A5_0001, 32'h0, mk(32'hA5A5_0001, 0, 0, 0, 1), 1, w);
        applyStimulus("srl_31", OP_SRL, 32'h8000_0000, 32'h1F, mk(32'h1, 0, 0, 0, 0), 1, w);
        applyStimulus("sltu", OP_SLTU, 32'h5, 32'h7, mk(32'h1, 0, 0, 0, 0), 1, w);
        applyStimulus("eq", OP_EQ, 32'h9, 32'h9, mk(32'h1, 0, 0, 0, 0), 1, w);
        applyStimulus("and_zero", OP_AND, 32'hF0F0, 32'h0F0F, mk(32'h0, 0, 0, 1, 0), 1, w);
        applyStimulus("nor_zero", OP_NOR, 32'h0, 32'h0, mk(32'hFFFF_FFFF, 0, 0, 0, 1), 1, w);

        applyStimulus("mul_small", OP_MUL, 32'hF6, 32'h0A, mk(32'h99C, 0, 0, 0, 0), 1, w);
        n      = 1;
        allLow = 1'b1;
        while (!out_valid && n < 100) begin
            if (in_ready) allLow = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("mul_latency", 64'(n), 64'd33);
        checkOutput("mul_in_ready_low", 64'(allLow), 64'd1);

        applyStimulus("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      mk(32'hFFFF_FFFE, 1, 0, 0, 1), 1, w);
        applyStimulus("mul_lo_carry", OP_MUL, 32'h1_0000, 32'h1_0000, mk(32'h0, 1, 0, 1, 0), 1, w);
        applyStimulus("mulhu_small", OP_MULHU, 32'h1234, 32'h10, mk(32'h0, 0, 0, 1, 0), 1, w);

        // Backpressure: hold an XOR result while the next operand set waits.
        applyStimulus("xor_pre_bp", OP_XOR, 32'h1, 32'h3, mk(32'h2, 0, 0, 0, 0), 1, w);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus("xor_bp", OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F,
                      mk(32'hF00F_F00F, 0, 0, 0, 1), 1, w);
        in_valid = 1'b1;
        op       = OP_OR;
        a        = 32'h0F;
        b        = 32'hF0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_result_hold", {32'd0, result}, 64'hF00F_F00F);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        applyStimulus("or_after_bp", OP_OR, 32'h0F, 32'hF0, mk(32'hFF, 0, 0, 0, 0), 1, w);
        checkOutput("bp_same_edge_accept", 64'(w), 64'd0);
        checkOutput("or_valid", 64'(out_valid), 64'd1);

        // Back-to-back burst with out_ready held high.
        repeat (2) @(posedge clk);
        #1;
        maxRun = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus("burst_add", OP_ADD, 32'(i), 32'd100, mk(32'(i + 100), 0, 0, 0, 0), 1, w);
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("burst_run_length", 64'(maxRun), 64'd16);

        // Reset in the middle of a multiply.
        applyStimulus("mul_aborted", OP_MUL, 32'h1234, 32'h5678, mk(32'h0, 0, 0, 0, 0), 0, w);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midmul_reset_outputs",
                    {28'd0, out_valid, result, carry, overflow, zero, negative}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("midmul_in_ready", 64'(in_ready), 64'd1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        checkOutput("midmul_no_stale", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus("add_after_reset", OP_ADD, 32'd2, 32'd3, mk(32'd5, 0, 0, 0, 0), 1, w);
        checkOutput("add_after_reset_latency", 64'(out_valid), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(expq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
